// File: rtl/isr_seq_if.sv
// Bundle between the square-root unit, its requester and the shared multiplier.
// The slave modport is the square-root unit; master is everything around it.
interface isr_seq_if #(
    parameter int VALUE_W = 64,
    parameter int MULT_W  = 64
);
    logic [VALUE_W-1:0]   value;
    logic                 start;
    logic [VALUE_W/2-1:0] result;
    logic                 done;
    logic                 mult_start;
    logic [MULT_W-1:0]    mult_mcand;
    logic [MULT_W-1:0]    mult_mplier;
    logic [MULT_W-1:0]    mult_product;
    logic                 mult_done;

    modport slave (
        input  value, start, mult_product, mult_done,
        output result, done, mult_start, mult_mcand, mult_mplier
    );

    modport master (
        output value, start, mult_product, mult_done,
        input  result, done, mult_start, mult_mcand, mult_mplier
    );
endinterface

// File: rtl/isr_seq.sv
// Sequential integer square root by bitwise trial. One result bit per
// multiply: the trial guess is squared on the shared multiplier and the bit
// is kept when the square does not exceed the latched radicand.
module isr_seq #(
    parameter int VALUE_W = 64,
    parameter int MULT_W  = 64
) (
    input  logic        clock,
    input  logic        reset,
    isr_seq_if.slave    bus
);
    localparam int RES_W = VALUE_W / 2;
    localparam int IDX_W = (RES_W > 1) ? $clog2(RES_W) : 1;

    localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(RES_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [RES_W-1:0] RES_ONE   = {{(RES_W-1){1'b0}}, 1'b1};
    localparam logic [RES_W-1:0] RES_ZERO  = {RES_W{1'b0}};
    localparam logic [RES_W-1:0] TOP_GUESS = RES_ONE << (RES_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic [VALUE_W-1:0]   value_q_r;
    logic [RES_W-1:0]     guess_r;
    logic                 first_wait_r;

    logic                 keep_s;
    logic [RES_W-1:0]     next_res_s;
    logic [IDX_W-1:0]     idx_dec_s;
    logic [RES_W-1:0]     next_guess_s;

    // Trial value for one bit: confirmed upper bits plus the bit under test.
    function automatic logic [RES_W-1:0] trial_guess(
        input logic [RES_W-1:0] base,
        input logic [IDX_W-1:0] idx
    );
        return base | (RES_ONE << idx);
    endfunction

    // Widen a guess onto the multiplier operand bus.
    function automatic logic [MULT_W-1:0] to_operand(input logic [RES_W-1:0] g);
        return {{(MULT_W-RES_W){1'b0}}, g};
    endfunction

    // Trial decision and the guess for the next lower bit.
    always_comb begin
        keep_s       = 1'b0;
        next_res_s   = bus.result;
        idx_dec_s    = bit_idx_r - IDX_ONE;
        next_guess_s = RES_ZERO;
        if (bus.mult_product <= value_q_r) begin
            keep_s = 1'b1;
        end else begin
            keep_s = 1'b0;
        end
        if (keep_s) begin
            next_res_s = guess_r;
        end else begin
            next_res_s = bus.result;
        end
        next_guess_s = trial_guess(next_res_s, idx_dec_s);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            bit_idx_r       <= TOP_IDX;
            value_q_r       <= {VALUE_W{1'b0}};
            guess_r         <= RES_ZERO;
            first_wait_r    <= 1'b0;
            bus.result      <= RES_ZERO;
            bus.done        <= 1'b0;
            bus.mult_start  <= 1'b0;
            bus.mult_mcand  <= {MULT_W{1'b0}};
            bus.mult_mplier <= {MULT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        value_q_r       <= bus.value;
                        bus.result      <= RES_ZERO;
                        bit_idx_r       <= TOP_IDX;
                        bus.done        <= 1'b0;
                        guess_r         <= TOP_GUESS;
                        bus.mult_mcand  <= to_operand(TOP_GUESS);
                        bus.mult_mplier <= to_operand(TOP_GUESS);
                        bus.mult_start  <= 1'b1;
                        state_r         <= ST_ISSUE;
                    end else begin
                        bus.mult_start  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    // A done still high from the previous multiply must not
                    // be taken as this request's answer, so skip one cycle.
                    bus.mult_start <= 1'b0;
                    first_wait_r   <= 1'b1;
                    state_r        <= ST_WAIT;
                end
                ST_WAIT: begin
                    first_wait_r <= 1'b0;
                    if (!first_wait_r && bus.mult_done) begin
                        bus.result <= next_res_s;
                        if (bit_idx_r == IDX_ZERO) begin
                            bus.done <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            bit_idx_r       <= idx_dec_s;
                            guess_r         <= next_guess_s;
                            bus.mult_mcand  <= to_operand(next_guess_s);
                            bus.mult_mplier <= to_operand(next_guess_s);
                            bus.mult_start  <= 1'b1;
                            state_r         <= ST_ISSUE;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    bus.mult_start <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_isr_seq.sv
// Bench for isr_seq: multiplier responder, reference square root by binary
// search, per-cycle comparison of multiplier operands and held results.
module tb_isr_seq;
    logic clock;
    logic reset;

    isr_seq_if #(.VALUE_W(64), .MULT_W(64)) bus ();

    isr_seq #(.VALUE_W(64), .MULT_W(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // multiplier responder configuration
    int   lat_fixed = 4;
    bit   rand_lat  = 1'b0;
    bit   sticky    = 1'b0;

    logic [63:0] opa, opb, mprod;
    logic        mdone, clr_pend;
    int          cnt;

    logic [31:0] exp_ops[$];
    logic [31:0] exp_result = 32'd0;
    int          pulses = 0;

    assign bus.mult_product = mprod;
    assign bus.mult_done    = mdone;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Largest r with r*r <= v, found by binary search in 128-bit arithmetic.
    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [127:0] lo, hi, mid;
        lo = 128'd0;
        hi = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
        while (lo < hi) begin
            mid = (lo + hi + 128'd1) >> 1;
            if (mid * mid <= {64'd0, v}) lo = mid;
            else hi = mid - 128'd1;
        end
        return lo[31:0];
    endfunction

    // Multiplier model: answers L cycles after sampling a request; in sticky
    // mode the previous done lingers one extra cycle after a new request.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt      <= 0;
            mdone    <= 1'b0;
            mprod    <= 64'd0;
            clr_pend <= 1'b0;
            opa      <= 64'd0;
            opb      <= 64'd0;
        end else if (bus.mult_start) begin
            cnt <= rand_lat ? int'($urandom_range(20, 1)) : lat_fixed;
            opa <= bus.mult_mcand;
            opb <= bus.mult_mplier;
            if (sticky) clr_pend <= 1'b1;
            else mdone <= 1'b0;
        end else begin
            if (clr_pend) begin
                mdone    <= 1'b0;
                clr_pend <= 1'b0;
            end
            if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    mdone <= 1'b1;
                    mprod <= opa * opb;
                end
            end
        end
    end

    // Per-cycle compare of operands and of the held result.
    always @(negedge clock) begin
        logic [31:0] g;
        if (reset) begin
            if (bus.mult_start) begin
                pulses++;
                if (exp_ops.size() == 0) begin
                    chk("extra_mult_start", 64'd1, 64'd0);
                end else begin
                    g = exp_ops.pop_front();
                    chk("mcand", bus.mult_mcand, {32'd0, g});
                    chk("mplier", bus.mult_mplier, {32'd0, g});
                end
            end
            if (bus.done) chk("result_hold", {32'd0, bus.result}, {32'd0, exp_result});
        end
    end

    // Drive a start on the next negedge and load expectations at acceptance.
    task automatic begin_op(input logic [63:0] v);
        logic [31:0] hi;
        @(negedge clock);
        bus.value = v;
        bus.start = 1'b1;
        @(posedge clock);
        exp_result = isqrt(v);
        exp_ops.delete();
        // trial for bit b = final result's bits above b, plus bit b itself
        for (int b = 31; b >= 0; b--) begin
            hi = (b == 31) ? 32'd0 : ((exp_result >> (b + 1)) << (b + 1));
            exp_ops.push_back(hi | (32'd1 << b));
        end
        pulses = 0;
        #1;
        bus.start = 1'b0;
        bus.value = ~v;
        chk("done_falls", {63'd0, bus.done}, 64'd0);
        chk("issue_pulse", {63'd0, bus.mult_start}, 64'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 2000) begin
            @(posedge clock);
            #1;
            lat++;
            if (bus.done) break;
        end
        chk("done_seen", {63'd0, bus.done}, 64'd1);
    endtask

    task automatic finish_op(input logic [63:0] v, input logic [31:0] lit, input bit has_lit,
                             input int exp_lat);
        int lat;
        logic [127:0] r;
        wait_done(lat);
        if (has_lit) chk("result_lit", {32'd0, bus.result}, {32'd0, lit});
        r = {96'd0, bus.result};
        chk("sq_le_value", {63'd0, (r * r <= {64'd0, v})}, 64'd1);
        chk("next_sq_gt_value", {63'd0, ((r + 128'd1) * (r + 128'd1) > {64'd0, v})}, 64'd1);
        chk("pulse_count", pulses, 64'd32);
        chk("ops_left", exp_ops.size(), 64'd0);
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
    endtask

    task automatic run_op(input logic [63:0] v, input logic [31:0] lit, input bit has_lit,
                          input int exp_lat);
        begin_op(v);
        if (has_lit) chk("model_pin", {32'd0, exp_result}, {32'd0, lit});
        finish_op(v, lit, has_lit, exp_lat);
    endtask

    typedef struct {
        logic [63:0] v;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [63:0] rv;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.value = 64'd0;
        #12;
        chk("rst_result", {32'd0, bus.result}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_mult_start", {63'd0, bus.mult_start}, 64'd0);
        chk("rst_mcand", bus.mult_mcand, 64'd0);
        chk("rst_mplier", bus.mult_mplier, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // fixed latency 4: every bit costs 1 issue + 5 wait cycles
        vecs.push_back('{64'd1001, 32'd31});
        vecs.push_back('{64'd144, 32'd12});
        vecs.push_back('{64'd143, 32'd11});
        vecs.push_back('{64'd0, 32'd0});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF});
        vecs.push_back('{64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF});
        vecs.push_back('{64'hFFFF_FFFE_0000_0000, 32'hFFFF_FFFE});
        foreach (vecs[i]) run_op(vecs[i].v, vecs[i].r, 1'b1, 192);

        // sticky multiplier done, random latency per request
        sticky   = 1'b1;
        rand_lat = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rv = {$urandom(), $urandom()};
            run_op(rv, 32'd0, 1'b0, -1);
        end
        sticky   = 1'b0;
        rand_lat = 1'b0;

        // start during WAIT is ignored
        begin_op(64'd100);
        @(negedge clock);
        @(negedge clock);
        bus.value = 64'd9;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        finish_op(64'd100, 32'd10, 1'b1, -1);

        // asynchronous reset in the WAIT of the second bit
        begin_op(64'hFFFF_FFFF_FFFF_FFFF);
        repeat (8) @(negedge clock);
        chk("pre_rst_result", {32'd0, bus.result}, 64'h0000_0000_8000_0000);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_done", {63'd0, bus.done}, 64'd0);
        chk("async_rst_result", {32'd0, bus.result}, 64'd0);
        chk("async_rst_mult_start", {63'd0, bus.mult_start}, 64'd0);
        chk("async_rst_mcand", bus.mult_mcand, 64'd0);
        exp_ops.delete();
        @(negedge clock);
        reset = 1'b1;
        run_op(64'd49, 32'd7, 1'b1, 192);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
